uart_tx_feeder: RTL and testbench

//  Byte FIFO + launch FSM sitting directly upstream of the UART transmitter. Producers
//  (sensor formatters, stopwatch/DHT11/SR04 report logic) push bytes whenever free; this block

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 74 +++++++
 rtl/uart_tx_feeder.sv | 123 ++++++++++++
 tb/tb_uart_tx_feeder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width and feeder FSM encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    FD_IDLE      = 2'd0,
    FD_WAIT_BUSY = 2'd1,
    FD_WAIT_DONE = 2'd2
  } fd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO with registered full/empty/count and async-read storage.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = UART_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_ok, pop_ok;

  // Next pointers/count; flags are derived from the post-edge count so they are registered.
  always_comb begin
    push_ok  = push && !full_q;
    pop_ok   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop_ok) count_d = count_q - CNT_ONE;
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is left unreset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM feeding a UART transmitter one frame at a time.
//
// Transmitter handshake: a launch is a one-cycle start_trigger pulse with tx_data valid in
// the same cycle; the transmitter acknowledges by raising tx_busy the following cycle and
// signals frame completion by dropping it. tx_data is held from launch until that drop.
// A launch that is never acknowledged within BUSY_TIMEOUT cycles is abandoned (launch_err).
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count,
  output logic                   overflow,
  input  logic                   tx_busy,
  output logic                   start_trigger,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   launch_err,
  output logic [1:0]             dbg_state
);

  localparam int            TW         = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  fd_state_e              state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   start_q, start_d;
  logic                   launch_err_q, launch_err_d;
  logic                   overflow_q, overflow_d;
  logic                   pop;
  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   fifo_full, fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // Launch FSM: pop and trigger from IDLE, wait for busy acknowledge, then for frame end.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    tx_data_d    = tx_data_q;
    start_d      = 1'b0;
    launch_err_d = 1'b0;
    pop          = 1'b0;
    overflow_d   = push && fifo_full;
    case (state_q)
      FD_IDLE: begin
        // tx_busy is deliberately ignored here so a stale busy never stalls a launch.
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_data_d = fifo_rd_data;
          start_d   = 1'b1;
          timer_d   = '0;
          state_d   = FD_WAIT_BUSY;
        end
      end
      FD_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = FD_WAIT_DONE;
        end else if (timer_q == TIMER_LAST) begin
          launch_err_d = 1'b1;
          state_d      = FD_IDLE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      FD_WAIT_DONE: begin
        if (!tx_busy) state_d = FD_IDLE;
      end
      default: state_d = FD_IDLE;
    endcase
  end

  // FSM state, timeout timer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FD_IDLE;
      timer_q      <= '0;
      tx_data_q    <= '0;
      start_q      <= 1'b0;
      launch_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      tx_data_q    <= tx_data_d;
      start_q      <= start_d;
      launch_err_q <= launch_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign full          = fifo_full;
  assign empty         = fifo_empty;
  assign overflow      = overflow_q;
  assign start_trigger = start_q;
  assign tx_data       = tx_data_q;
  assign launch_err    = launch_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder paired with a simple transmitter busy model.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       full, empty, overflow, tx_busy, start_trigger, launch_err;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic [1:0] dbg_state;

  // Transmitter model controls.
  logic ignore_trig;
  logic busy_force;
  int   busy_len;
  int   busy_cnt;

  // Scoreboard and monitor state.
  logic [7:0] exp_q[$];
  logic [7:0] last_sent;
  int  total, bad;
  int  cyc;
  int  trig_total, err_total, ovf_total;
  int  fall_cyc;
  logic fall_valid, prev_busy, prev_start, gap_chk;

  uart_tx_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .push_data     (push_data),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .tx_busy       (tx_busy),
    .start_trigger (start_trigger),
    .tx_data       (tx_data),
    .launch_err    (launch_err),
    .dbg_state     (dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises the cycle after a trigger and lasts busy_len cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) busy_cnt <= 0;
    else if (start_trigger && !ignore_trig) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || busy_force;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: scoreboard on each launch, hold/gap checks around busy falling edges.
  always @(negedge clk) begin
    if (!rst) begin
      prev_busy  = 1'b0;
      prev_start = 1'b0;
      fall_valid = 1'b0;
    end else begin
      if (launch_err) err_total++;
      if (overflow)   ovf_total++;
      if (start_trigger) begin
        trig_total++;
        check_eq("trig_dbl", 32'(prev_start), 32'(0));
        check_eq("q_nonempty", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        if (gap_chk && fall_valid) check_eq("gap", 32'(cyc - fall_cyc), 32'(2));
        fall_valid = 1'b0;
        last_sent  = tx_data;
      end
      if (prev_busy && !tx_busy) begin
        check_eq("tx_hold", 32'(tx_data), 32'(last_sent));
        fall_cyc   = cyc;
        fall_valid = 1'b1;
      end
      if (count > 5'd16) check_eq("cnt_max", 32'(count), 32'(16));
      prev_busy  = tx_busy;
      prev_start = start_trigger;
    end
  end

  task automatic wait_trig(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!start_trigger && n < budget);
    check_eq("trig_to", 32'(start_trigger), 32'(1));
  endtask

  task automatic wait_fall(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_busy && n < budget);
    check_eq("fall_to", 32'(tx_busy), 32'(0));
  endtask

  task automatic wait_idle(input int budget);
    int   n = 0;
    logic done;
    do begin
      @(negedge clk);
      n++;
      done = empty && !tx_busy && (dbg_state == FD_IDLE);
    end while (!done && n < budget);
    check_eq("idle_to", 32'(done), 32'(1));
  endtask

  task automatic push_one(input logic [7:0] b);
    @(negedge clk);
    push      = 1'b1;
    push_data = b;
    exp_q.push_back(b);
    @(negedge clk);
    push = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    total = 0; bad = 0;
    trig_total = 0; err_total = 0; ovf_total = 0;
    fall_cyc = 0; fall_valid = 1'b0; prev_busy = 1'b0; prev_start = 1'b0;
    gap_chk = 1'b0; last_sent = 8'h00;
    rst = 1'b0; push = 1'b0; push_data = 8'h00;
    ignore_trig = 1'b0; busy_force = 1'b0; busy_len = 160;

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_count", 32'(count), 32'(0));
    check_eq("rst_empty", 32'(empty), 32'(1));
    check_eq("rst_full", 32'(full), 32'(0));
    check_eq("rst_trig", 32'(start_trigger), 32'(0));
    check_eq("rst_txd", 32'(tx_data), 32'(0));
    check_eq("rst_ovf", 32'(overflow), 32'(0));
    check_eq("rst_err", 32'(launch_err), 32'(0));
    check_eq("rst_state", 32'(dbg_state), 32'(FD_IDLE));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: trigger two edges after the push.
    @(negedge clk);
    push = 1'b1; push_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    push = 1'b0;
    check_eq("sb_count1", 32'(count), 32'(1));
    check_eq("sb_notrig", 32'(start_trigger), 32'(0));
    @(negedge clk);
    check_eq("sb_trig", 32'(start_trigger), 32'(1));
    check_eq("sb_txd", 32'(tx_data), 32'(8'hA5));
    check_eq("sb_count0", 32'(count), 32'(0));
    @(negedge clk);
    check_eq("sb_pulse", 32'(start_trigger), 32'(0));
    wait_fall(400);
    wait_idle(50);

    // Reset mid-frame with three bytes queued.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      push = 1'b1; push_data = 8'hC0 + 8'(i); exp_q.push_back(8'hC0 + 8'(i));
    end
    @(negedge clk);
    push = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mr_count3", 32'(count), 32'(3));
    check_eq("mr_state", 32'(dbg_state), 32'(FD_WAIT_DONE));
    rst = 1'b0;
    #1;
    check_eq("mr_count", 32'(count), 32'(0));
    check_eq("mr_empty", 32'(empty), 32'(1));
    check_eq("mr_full", 32'(full), 32'(0));
    check_eq("mr_trig", 32'(start_trigger), 32'(0));
    check_eq("mr_txd", 32'(tx_data), 32'(0));
    check_eq("mr_state0", 32'(dbg_state), 32'(FD_IDLE));
    exp_q.delete();
    snap = trig_total;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("mr_notrig", 32'(trig_total), 32'(snap));
    check_eq("mr_empty2", 32'(empty), 32'(1));

    // Burst to full while a frame is in flight, then one overflowing push.
    push_one(8'h2F);
    wait_trig(10);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      push = 1'b1; push_data = 8'h30 + 8'(i); exp_q.push_back(8'h30 + 8'(i));
    end
    @(negedge clk);
    check_eq("bu_full", 32'(full), 32'(1));
    check_eq("bu_count16", 32'(count), 32'(16));
    check_eq("bu_noovf", 32'(overflow), 32'(0));
    push_data = 8'h40;
    @(negedge clk);
    push = 1'b0;
    check_eq("bu_ovf", 32'(overflow), 32'(1));
    check_eq("bu_count_keep", 32'(count), 32'(16));
    @(negedge clk);
    check_eq("bu_ovf_pulse", 32'(overflow), 32'(0));
    gap_chk = 1'b1;
    wait_idle(4000);
    gap_chk = 1'b0;
    check_eq("bu_drained", 32'(exp_q.size()), 32'(0));

    // Wrap with short frames; first a deliberate push on the pop edge.
    busy_len = 4;
    snap = ovf_total;
    push_one(8'h80);
    wait_trig(10);
    push_one(8'h81);
    wait_fall(20);
    @(negedge clk);
    push = 1'b1; push_data = 8'h82; exp_q.push_back(8'h82);
    check_eq("wr_idle", 32'(dbg_state), 32'(FD_IDLE));
    check_eq("wr_cnt_pre", 32'(count), 32'(1));
    @(negedge clk);
    push = 1'b0;
    check_eq("wr_pp_trig", 32'(start_trigger), 32'(1));
    check_eq("wr_pp_cnt", 32'(count), 32'(1));
    for (int i = 3; i < 40; i++) begin
      push_one(8'h80 + 8'(i));
      repeat (3 + (i % 4)) @(negedge clk);
    end
    wait_idle(600);
    check_eq("wr_empty", 32'(empty), 32'(1));
    check_eq("wr_drained", 32'(exp_q.size()), 32'(0));
    check_eq("wr_noovf", 32'(ovf_total), 32'(snap));
    busy_len = 160;

    // Launch timeout: model ignores triggers.
    ignore_trig = 1'b1;
    @(negedge clk);
    push = 1'b1; push_data = 8'h11; exp_q.push_back(8'h11);
    @(negedge clk);
    push_data = 8'h22; exp_q.push_back(8'h22);
    @(negedge clk);
    push = 1'b0;
    check_eq("to_trig1", 32'(start_trigger), 32'(1));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq("to_err1", 32'(launch_err), 32'(k == 4));
    end
    @(negedge clk);
    check_eq("to_trig2", 32'(start_trigger), 32'(1));
    check_eq("to_err_pulse", 32'(launch_err), 32'(0));
    repeat (3) @(negedge clk);
    @(negedge clk);
    check_eq("to_err2", 32'(launch_err), 32'(1));
    snap = trig_total;
    repeat (20) @(negedge clk);
    check_eq("to_noretry", 32'(trig_total), 32'(snap));
    check_eq("to_empty", 32'(empty), 32'(1));
    check_eq("to_drained", 32'(exp_q.size()), 32'(0));

    // Stale busy at idle does not block a launch.
    snap = err_total;
    busy_force = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    push = 1'b1; push_data = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk);
    push = 1'b0;
    @(negedge clk);
    check_eq("sb_stale_trig", 32'(start_trigger), 32'(1));
    repeat (10) @(negedge clk);
    check_eq("sb_stale_wait", 32'(dbg_state), 32'(FD_WAIT_DONE));
    check_eq("sb_stale_noerr", 32'(err_total), 32'(snap));
    #1 busy_force = 1'b0;
    @(negedge clk);
    check_eq("sb_stale_idle", 32'(dbg_state), 32'(FD_IDLE));
    check_eq("sb_stale_txd", 32'(tx_data), 32'(8'h5A));
    ignore_trig = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
